// File: rtl/ysyx_24090018_ifu_ctrl.sv
// Instruction-fetch controller: owns the fetch PC and runs one request/response to imem at a time, then hands the instruction to the IDU.
// Latency: REQ, WAIT, HOLD gives 3 cycles per instruction with zero-wait memory and IDU; stalls on req_ready/inst_ready, and redirects discard the in-flight fetch.
module ysyx_24090018_ifu_ctrl #(
  parameter int unsigned          ADDR_WIDTH = 32,
  parameter int unsigned          DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] PC_BASE   = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  input  logic                  imem_rsp_err,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] inst_o,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic                  inst_fault,
  output logic [ADDR_WIDTH-1:0] pc_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_DROP = 3'd4
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_inst;
  logic                  r_fault;
  logic                  r_req_vld;
  logic                  r_inst_vld;

  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] w_pc_nxt;
  logic [DATA_WIDTH-1:0] w_inst_nxt;
  logic                  w_fault_nxt;
  logic [ADDR_WIDTH-1:0] w_redir_pc;
  logic [ADDR_WIDTH-1:0] w_pc_inc;

  // Redirect targets are forced word-aligned; the increment wraps naturally at 2^ADDR_WIDTH.
  assign w_redir_pc = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
  assign w_pc_inc   = r_pc + ADDR_WIDTH'(4);

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_inst_nxt  = r_inst;
    w_fault_nxt = r_fault;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (redirect_valid) begin
          w_pc_nxt = w_redir_pc;
          // An accepted request still returns a response for the old address.
          if (imem_req_ready) w_state_nxt = S_DROP;
        end else if (imem_req_ready) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          w_pc_nxt    = w_redir_pc;
          w_state_nxt = imem_rsp_valid ? S_REQ : S_DROP;
        end else if (imem_rsp_valid) begin
          w_inst_nxt  = imem_rsp_err ? '0 : imem_rsp_data;
          w_fault_nxt = imem_rsp_err;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          w_pc_nxt    = w_redir_pc;
          w_state_nxt = S_REQ;
        end else if (inst_ready) begin
          w_pc_nxt    = w_pc_inc;
          w_state_nxt = S_REQ;
        end
      end
      S_DROP: begin
        if (redirect_valid) w_pc_nxt = w_redir_pc;
        if (imem_rsp_valid) w_state_nxt = S_REQ;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pc       <= PC_BASE;
      r_inst     <= '0;
      r_fault    <= 1'b0;
      r_req_vld  <= 1'b0;
      r_inst_vld <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_inst     <= w_inst_nxt;
      r_fault    <= w_fault_nxt;
      r_req_vld  <= (w_state_nxt == S_REQ);
      r_inst_vld <= (w_state_nxt == S_HOLD);
    end
  end

  assign imem_req_valid = r_req_vld;
  assign imem_req_addr  = r_pc;
  assign inst_valid     = r_inst_vld;
  assign inst_o         = r_inst;
  assign inst_pc        = r_pc;
  assign inst_fault     = r_fault;
  assign pc_o           = r_pc;

endmodule

// File: tb/tb_ysyx_24090018_ifu_ctrl.sv
// Directed bench for ysyx_24090018_ifu_ctrl with hand-computed expectations.
module tb_ysyx_24090018_ifu_ctrl;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_o;
  logic [31:0] inst_pc;
  logic        inst_fault;
  logic [31:0] pc_o;

  int n_checks = 0;
  int n_errors = 0;

  ysyx_24090018_ifu_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_o         (inst_o),
    .inst_pc        (inst_pc),
    .inst_fault     (inst_fault),
    .pc_o           (pc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    imem_rsp_err   = 1'b0;
    inst_ready     = 1'b0;
  endtask

  // Starting in REQ at address a: accept the request, return data/err, check HOLD contents.
  task automatic fetch_to_hold(input string tag, input logic [31:0] a,
                               input logic [31:0] data, input logic err);
    check({tag, "_req_vld"}, {31'd0, imem_req_valid}, 32'd1);
    check({tag, "_req_addr"}, imem_req_addr, a);
    idle_inputs();
    imem_req_ready = 1'b1;
    tick();
    check({tag, "_wait_req_vld"}, {31'd0, imem_req_valid}, 32'd0);
    idle_inputs();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    imem_rsp_err   = err;
    tick();
    idle_inputs();
    check({tag, "_inst_vld"}, {31'd0, inst_valid}, 32'd1);
    check({tag, "_inst_o"}, inst_o, err ? 32'd0 : data);
    check({tag, "_inst_pc"}, inst_pc, a);
    check({tag, "_fault"}, {31'd0, inst_fault}, {31'd0, err});
  endtask

  task automatic accept_inst();
    idle_inputs();
    inst_ready = 1'b1;
    tick();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    imem_rsp_valid = 1'b1;
    tick();
    tick();
    check("rst_pc", pc_o, 32'h8000_0000);
    check("rst_req_vld", {31'd0, imem_req_valid}, 32'd0);
    check("rst_inst_vld", {31'd0, inst_valid}, 32'd0);
    check("rst_inst_o", inst_o, 32'd0);
    check("rst_fault", {31'd0, inst_fault}, 32'd0);

    // First cycle out of reset is IDLE; a stale response there is ignored.
    rst = 1'b0;
    check("idle_req_vld", {31'd0, imem_req_valid}, 32'd0);
    tick();
    idle_inputs();
    check("first_req_vld", {31'd0, imem_req_valid}, 32'd1);
    check("first_inst_vld", {31'd0, inst_valid}, 32'd0);

    // Zero-wait streaming: three fetches, 3 cycles each.
    for (int i = 0; i < 3; i++) begin
      fetch_to_hold("seq", 32'h8000_0000 + 32'(4 * i), 32'h1000_0013 + 32'(i), 1'b0);
      accept_inst();
      check("seq_after_acc_inst_vld", {31'd0, inst_valid}, 32'd0);
    end

    // Request backpressure: address held for 4 cycles.
    for (int i = 0; i < 4; i++) begin
      check("bp_req_vld", {31'd0, imem_req_valid}, 32'd1);
      check("bp_req_addr", imem_req_addr, 32'h8000_000C);
      tick();
    end
    fetch_to_hold("bp", 32'h8000_000C, 32'hCAFE_0001, 1'b0);
    // IDU backpressure: instruction held for 3 cycles.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_vld", {31'd0, inst_valid}, 32'd1);
      check("bp_hold_inst", inst_o, 32'hCAFE_0001);
      check("bp_hold_pc", inst_pc, 32'h8000_000C);
    end
    accept_inst();
    check("bp_next_addr", imem_req_addr, 32'h8000_0010);

    // Redirect in WAIT before the response: one response dropped.
    imem_req_ready = 1'b1;
    tick();
    idle_inputs();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0103;
    tick();
    idle_inputs();
    check("drop_pc", pc_o, 32'h8000_0100);
    check("drop_req_vld", {31'd0, imem_req_valid}, 32'd0);
    tick();
    check("drop_wait_req_vld", {31'd0, imem_req_valid}, 32'd0);
    check("drop_wait_inst_vld", {31'd0, inst_valid}, 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hBAD0_BAD0;
    tick();
    idle_inputs();
    check("drop_done_inst_vld", {31'd0, inst_valid}, 32'd0);

    // Redirect in HOLD beats a simultaneous inst_ready.
    fetch_to_hold("hr", 32'h8000_0100, 32'h0000_0297, 1'b0);
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0200;
    tick();
    idle_inputs();
    check("hr_inst_vld", {31'd0, inst_valid}, 32'd0);
    check("hr_req_addr", imem_req_addr, 32'h8000_0200);

    // Access fault: data zeroed, pc still advances on accept.
    fetch_to_hold("flt", 32'h8000_0200, 32'hDEAD_BEEF, 1'b1);
    accept_inst();
    check("flt_next_addr", imem_req_addr, 32'h8000_0204);

    // Redirect in REQ without ready, to the top of the address space, then wrap.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    tick();
    idle_inputs();
    check("wrap_redir_vld", {31'd0, imem_req_valid}, 32'd1);
    fetch_to_hold("wrap", 32'hFFFF_FFFC, 32'h1234_5678, 1'b0);
    accept_inst();
    check("wrap_next_addr", imem_req_addr, 32'h0000_0000);

    // Redirect in REQ with ready goes to DROP; a second redirect with the dropped response lands.
    imem_req_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0300;
    tick();
    idle_inputs();
    check("rq_drop_req_vld", {31'd0, imem_req_valid}, 32'd0);
    check("rq_drop_pc", pc_o, 32'h8000_0300);
    imem_rsp_valid = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0400;
    tick();
    idle_inputs();
    check("rq_drop_inst_vld", {31'd0, inst_valid}, 32'd0);
    check("rq_drop_req_addr", imem_req_addr, 32'h8000_0400);
    check("rq_drop_req_vld2", {31'd0, imem_req_valid}, 32'd1);

    // Redirect in WAIT coincident with the response: straight back to REQ.
    imem_req_ready = 1'b1;
    tick();
    idle_inputs();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h7777_7777;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0500;
    tick();
    idle_inputs();
    check("wr_inst_vld", {31'd0, inst_valid}, 32'd0);
    check("wr_req_vld", {31'd0, imem_req_valid}, 32'd1);
    check("wr_req_addr", imem_req_addr, 32'h8000_0500);

    // Reset mid-WAIT with a late response; inst_o currently nonzero from the wrap fetch.
    check("pre_rst_inst_o", inst_o, 32'h1234_5678);
    imem_req_ready = 1'b1;
    tick();
    idle_inputs();
    rst            = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h5555_AAAA;
    tick();
    check("wrst_pc", pc_o, 32'h8000_0000);
    check("wrst_req_vld", {31'd0, imem_req_valid}, 32'd0);
    check("wrst_inst_vld", {31'd0, inst_valid}, 32'd0);
    check("wrst_inst_o", inst_o, 32'd0);
    rst = 1'b0;
    tick();
    check("late_rsp_req_vld", {31'd0, imem_req_valid}, 32'd1);
    check("late_rsp_inst_vld", {31'd0, inst_valid}, 32'd0);
    tick();
    check("late_rsp_req_stay", {31'd0, imem_req_valid}, 32'd1);
    check("late_rsp_inst_vld2", {31'd0, inst_valid}, 32'd0);
    idle_inputs();
    fetch_to_hold("post", 32'h8000_0000, 32'h0010_0073, 1'b0);
    accept_inst();
    check("post_next_addr", imem_req_addr, 32'h8000_0004);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ysyx_24090018_ifu_ctrl.md
Name: ysyx_24090018_ifu_ctrl

Overview:
Instruction-fetch controller. Owns the fetch PC and sequences it through a valid/ready request and response handshake to instruction memory. Presents each fetched instruction to decode with a valid/ready handshake. Applies redirects (jump, branch, trap) from later stages, including discarding any in-flight response. Sits between the core's next-PC logic, the instruction memory port and the IDU.

Parameters:
ADDR_WIDTH, 32, width of PC and memory address
DATA_WIDTH, 32, instruction width
PC_BASE, 32'h8000_0000, PC value after reset

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous reset, active-high
redirect_valid  in  1  redirect fetch to redirect_pc this cycle
redirect_pc  in  ADDR_WIDTH  redirect target
imem_req_valid  out  1  fetch request valid (registered)
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  ADDR_WIDTH  fetch address, equals pc_o
imem_rsp_valid  in  1  response valid (memory cannot stall it)
imem_rsp_data  in  DATA_WIDTH  fetched instruction
imem_rsp_err  in  1  access fault on this response
inst_valid  out  1  instruction available to IDU
inst_ready  in  1  IDU accepts instruction
inst_o  out  DATA_WIDTH  held instruction
inst_pc  out  ADDR_WIDTH  PC of held instruction, equals pc_o
inst_fault  out  1  held instruction carries access fault
pc_o  out  ADDR_WIDTH  current fetch PC register

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE, pc_o=PC_BASE.
  - imem_req_valid=0, inst_valid=0, inst_o=0, inst_fault=0.
  - rst overrides every other input, including mid-transaction.
  - After reset, a stale imem_rsp_valid arriving in IDLE or REQ is ignored.
- States: IDLE, REQ, WAIT, HOLD, DROP. Outputs by state:
  - imem_req_valid=1 only in REQ.
  - inst_valid=1 only in HOLD.
- IDLE: go to REQ next cycle unconditionally. The first request is visible on the 2nd cycle after rst deasserts.
- REQ:
  - imem_req_addr=pc_o, held stable until accepted, except on redirect.
  - redirect & !req_ready: pc_o<=redirect_pc, stay REQ.
  - redirect & req_ready: pc_o<=redirect_pc, go DROP (the old-address response is in flight).
  - !redirect & req_ready: go WAIT.
- WAIT:
  - redirect & rsp_valid: discard response, pc_o<=redirect_pc, go REQ.
  - redirect & !rsp_valid: pc_o<=redirect_pc, go DROP.
  - !redirect & rsp_valid: inst_o<=rsp_data, inst_fault<=rsp_err, go HOLD.
  - If rsp_err=1, inst_o<=0 instead.
- HOLD:
  - redirect: drop the instruction, pc_o<=redirect_pc, go REQ. Redirect wins over a simultaneous inst_ready.
  - inst_ready: pc_o<=pc_o+4, go REQ.
  - Otherwise hold inst_o, inst_pc and inst_fault stable.
- DROP:
  - rsp_valid: discard it, go REQ.
  - A further redirect updates pc_o (same cycle as rsp_valid or not).
  - Exactly one response is discarded per DROP entry.
- Redirect priority: redirect_pc is always written to pc_o with bits [1:0] forced to 0.
- Arithmetic: pc_o+4 is modulo 2^ADDR_WIDTH, so 32'hFFFF_FFFC wraps to 0.
- A faulting instruction accepted without a redirect still advances pc by 4.
- Throughput: with zero-wait memory and IDU, one instruction per 3 cycles (REQ, WAIT, HOLD). At most one outstanding request.
- imem_rsp_valid in IDLE, REQ or HOLD is a protocol violation; the controller ignores it.

Test Plan:
- Reset, then ready=1 and single-cycle response: first req_addr=0x8000_0000 at cycle 2; inst_pc sequence 0x8000_0000, 0x8000_0004, 0x8000_0008; inst_valid once every 3 cycles.
- Backpressure: req_ready low 4 cycles, then inst_ready low 3 cycles → addr and inst_o stable throughout; pc advances exactly +4 per acceptance.
- Redirect in WAIT before response (redirect_pc=0x8000_0103): response discarded, next req_addr=0x8000_0100, no inst_valid for the dropped fetch.
- Redirect in HOLD with inst_ready=1 same cycle, redirect_pc=0x8000_0200: instruction not counted; next req_addr=0x8000_0200.
- rsp_err=1 with data 0xDEAD_BEEF → inst_fault=1, inst_o=0; next fetch after accept at pc+4. Also pc=0xFFFF_FFFC accepted → next req_addr=0x0000_0000.
- rst asserted in WAIT: next cycle state IDLE, pc_o=0x8000_0000, all valids 0; a late rsp_valid is ignored.
